// File: rtl/upg_pkg.sv
// Shared types and constants for the instruction-RAM word loader.
package upg_pkg;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StLenLo,
        StLenHi,
        StData,
        StChk,
        StDone,
        StErr
    } upg_state_e;

endpackage

// File: rtl/upg_timeout_ctr.sv
// Inter-byte watchdog: reloads on clear_i, counts down while en_i, flags the last idle cycle.
module upg_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned       CntW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0]   LoadVal = CntW'(TIMEOUT_CYC);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LoadVal;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LoadVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle, so the FSM leaves on that edge.
    assign expired_o = en_i && !clear_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/upg_word_loader.sv
// Frames UART bytes (sync, 16-bit LE count, LE words) into fetch-RAM programming writes.
// Optional trailing mod-256 checksum byte enabled by defining UPG_CHKSUM_EN.
module upg_word_loader
    import upg_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned DATA_W      = 32,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_addr_o,
    output logic [DATA_W-1:0] upg_data_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [32:0] MaxWords = 33'd1 << ADDR_W;

    upg_state_e        state_q;
    logic [15:0]       count_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [DATA_W-1:0] pack_q, data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q, done_q, err_q;
`ifdef UPG_CHKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic        timed, tmo_en, tmo_expired;
    logic [15:0] len_next;
    logic        last_byte, last_word;

    assign len_next  = {rx_data_i, count_q[7:0]};
    assign last_byte = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
    assign last_word = (33'(word_idx_q) + 33'd1 == 33'(count_q));
    assign timed     = state_q inside {StLenLo, StLenHi, StData, StChk};
    assign tmo_en    = timed && !rx_valid_i;

    upg_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!tmo_en),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            pack_q     <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UPG_CHKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start_i) begin
                        state_q    <= StSync;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
`ifdef UPG_CHKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                StSync: begin
                    if (rx_valid_i && rx_data_i == SYNC_BYTE) state_q <= StLenLo;
                end
                StLenLo: begin
                    if (rx_valid_i) begin
                        count_q[7:0] <= rx_data_i;
                        state_q      <= StLenHi;
                    end else if (tmo_expired) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                    end
                end
                StLenHi: begin
                    if (rx_valid_i) begin
                        count_q[15:8] <= rx_data_i;
                        if (len_next == 16'd0) begin
`ifdef UPG_CHKSUM_EN
                            state_q <= StChk;
`else
                            state_q <= StDone;
                            done_q  <= 1'b1;
`endif
                        end else if (33'(len_next) > MaxWords) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= StData;
                        end
                    end else if (tmo_expired) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                    end
                end
                StData: begin
`ifndef UPG_CHKSUM_EN
                    // Final write is on the bus this cycle; done follows it by one cycle.
                    if (wen_q && 33'(word_idx_q) == 33'(count_q)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else
`endif
                    if (rx_valid_i) begin
                        pack_q[{byte_idx_q, 3'b000} +: 8] <= rx_data_i;
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef UPG_CHKSUM_EN
                        sum_q      <= sum_q + rx_data_i;
`endif
                        if (last_byte) begin
                            wen_q      <= 1'b1;
                            addr_q     <= word_idx_q[ADDR_W-1:0];
                            data_q     <= {rx_data_i, pack_q[DATA_W-9:0]};
                            word_idx_q <= word_idx_q + 1'b1;
`ifdef UPG_CHKSUM_EN
                            if (last_word) state_q <= StChk;
`endif
                        end
                    end else if (tmo_expired) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                    end
                end
`ifdef UPG_CHKSUM_EN
                StChk: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == sum_q) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end
                    end else if (tmo_expired) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_addr_o = addr_q;
    assign upg_data_o = data_q;
    assign upg_done_o = done_q;
    assign err_o      = err_q;
    assign busy_o     = state_q inside {StSync, StLenLo, StLenHi, StData, StChk};

endmodule

// File: tb/tb_upg_word_loader.sv
// Self-checking bench for upg_word_loader: vector table, corner sequences, random frames.
`timescale 1ns/1ps
module tb_upg_word_loader;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TMO       = 40;
    localparam int          MAX_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              rx_valid_i = 1'b0;
    logic [7:0]        rx_data_i = 8'h00;
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_addr_o;
    logic [DATA_W-1:0] upg_data_o;
    logic              upg_done_o;
    logic              busy_o;
    logic              err_o;

    upg_word_loader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .upg_wen_o  (upg_wen_o),
        .upg_addr_o (upg_addr_o),
        .upg_data_o (upg_data_o),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef logic [ADDR_W+DATA_W-1:0] wr_t;
    typedef struct {
        logic [95:0] bytes;   // byte k at [8k+7:8k]
        int          len;
        bit          add_chk;
        logic [7:0]  chk;
        bit          exp_done;
        bit          exp_err;
        int          exp_nw;
        logic [31:0] exp_w0;
    } vec_t;

    vec_t vecs [6];
    wr_t  got_q [$];
    wr_t  exp_q [$];
    bit   exp_done, exp_err;
    int   checks = 0;
    int   passes = 0;

    always @(negedge clk) begin
        if (rst_n && upg_wen_o) got_q.push_back({upg_addr_o, upg_data_o});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        idle(1);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        idle(1);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_bytes(input logic [95:0] bytes, input int n);
        for (int k = 0; k < n; k++) send_byte(bytes[8*k +: 8]);
    endtask

    // Reference: parse the frame from the byte stream with plain arithmetic.
    task automatic model_frame(input logic [7:0] b[$]);
        int         i = 0;
        int         n, p;
        logic [7:0] sum = 8'h00;
        logic [31:0] w;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i + 2 >= b.size()) begin
            exp_err = (i < b.size());
            return;
        end
        n = int'({b[i+2], b[i+1]});
        p = i + 3;
        if (n > MAX_WORDS) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (p + 4 > b.size()) begin
                exp_err = 1'b1;
                return;
            end
            w = {b[p+3], b[p+2], b[p+1], b[p]};
            for (int j = 0; j < 4; j++) sum = sum + b[p+j];
            exp_q.push_back({ADDR_W'(k), w});
            p += 4;
        end
`ifdef UPG_CHKSUM_EN
        if (p >= b.size()) exp_err = 1'b1;
        else if (b[p] == sum) exp_done = 1'b1;
        else exp_err = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    initial begin
        logic [7:0] q [$];
        int         nw, nd;
        logic [7:0] s;

        vecs[0] = '{96'h00_10_00_93_00_00_00_13_00_02_A5, 11, 1'b1, 8'hB6, 1'b1, 1'b0, 2,
                    32'h0000_0013};
        vecs[1] = '{96'h00_00_A5_7F_3C, 5, 1'b1, 8'h00, 1'b1, 1'b0, 0, 32'h0};
        vecs[2] = '{96'h40_01_A5, 3, 1'b0, 8'h00, 1'b0, 1'b1, 0, 32'h0};
        vecs[3] = '{96'hDE_AD_BE_EF_00_01_A5, 7, 1'b1, 8'h38, 1'b1, 1'b0, 1, 32'hDEAD_BEEF};
        vecs[4] = '{96'hFF_FF_A5, 3, 1'b0, 8'h00, 1'b0, 1'b1, 0, 32'h0};
        vecs[5] = '{96'h00_13_00_01_A5, 5, 1'b0, 8'h00, 1'b0, 1'b1, 0, 32'h0};

        idle(3);
        check("reset wen", 64'(upg_wen_o), 64'd0);
        check("reset done", 64'(upg_done_o), 64'd0);
        check("reset err", 64'(err_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Table of whole frames.
        for (int r = 0; r < 6; r++) begin
            got_q.delete();
            pulse_start();
            send_bytes(vecs[r].bytes, vecs[r].len);
`ifdef UPG_CHKSUM_EN
            if (vecs[r].add_chk) send_byte(vecs[r].chk);
`endif
            idle(TMO + 5);
            check($sformatf("vec%0d done", r), 64'(upg_done_o), 64'(vecs[r].exp_done));
            check($sformatf("vec%0d err", r), 64'(err_o), 64'(vecs[r].exp_err));
            check($sformatf("vec%0d busy", r), 64'(busy_o), 64'd0);
            check($sformatf("vec%0d nwrites", r), 64'(got_q.size()), 64'(vecs[r].exp_nw));
            if (vecs[r].exp_nw > 0 && got_q.size() > 0)
                check($sformatf("vec%0d word0", r), 64'(got_q[0]), 64'({14'd0, vecs[r].exp_w0}));
        end

        // Cycle-exact write and done timing for the two-word frame.
        got_q.delete();
        pulse_start();
        send_bytes(vecs[0].bytes, vecs[0].len);
        check("t2 wen", 64'(upg_wen_o), 64'd1);
        check("t2 addr", 64'(upg_addr_o), 64'd1);
        check("t2 data", 64'(upg_data_o), 64'h0010_0093);
`ifdef UPG_CHKSUM_EN
        send_byte(8'hB6);
        check("t6 done", 64'(upg_done_o), 64'd1);
        check("t6 busy", 64'(busy_o), 64'd0);
        got_q.delete();
        pulse_start();
        check("t6 start clears done", 64'(upg_done_o), 64'd0);
        send_bytes(vecs[0].bytes, vecs[0].len);
        send_byte(8'hB7);
        check("t6 bad chk err", 64'(err_o), 64'd1);
        check("t6 bad chk done", 64'(upg_done_o), 64'd0);
        check("t6 bad chk writes", 64'(got_q.size()), 64'd2);
`else
        idle(1);
        check("t2 wen pulse", 64'(upg_wen_o), 64'd0);
        check("t2 done", 64'(upg_done_o), 64'd1);
        check("t2 busy", 64'(busy_o), 64'd0);
`endif

        // Timeout bounds, then start clears err.
        got_q.delete();
        pulse_start();
        send_bytes(vecs[5].bytes, vecs[5].len);
        idle(TMO - 2);
        check("t4 early err", 64'(err_o), 64'd0);
        check("t4 early busy", 64'(busy_o), 64'd1);
        idle(4);
        check("t4 err", 64'(err_o), 64'd1);
        check("t4 done", 64'(upg_done_o), 64'd0);
        check("t4 no write", 64'(got_q.size()), 64'd0);
        pulse_start();
        check("t4 start clears err", 64'(err_o), 64'd0);
        check("t4 busy again", 64'(busy_o), 64'd1);

        // N == 2^ADDR_W is legal; start while busy is ignored.
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h40);
        check("max N no err", 64'(err_o), 64'd0);
        check("max N busy", 64'(busy_o), 64'd1);
        idle(TMO + 5);
        check("max N timeout", 64'(err_o), 64'd1);

        // Reset mid-DATA aborts; bytes without start are ignored.
        pulse_start();
        send_bytes(vecs[0].bytes, 8);
        rst_n = 1'b0;
        #1;
        check("rst wen", 64'(upg_wen_o), 64'd0);
        check("rst addr", 64'(upg_addr_o), 64'd0);
        check("rst data", 64'(upg_data_o), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst done/err", 64'({upg_done_o, err_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        got_q.delete();
        send_bytes(vecs[3].bytes, vecs[3].len);
        idle(5);
        check("no start busy", 64'(busy_o), 64'd0);
        check("no start writes", 64'(got_q.size()), 64'd0);

        // Random frames against the reference parser.
        for (int f = 0; f < 40; f++) begin
            q.delete();
            s = 8'h00;
            for (int j = 0; j < int'($urandom_range(2, 0)); j++)
                q.push_back(8'h3C ^ 8'($urandom_range(15, 0)));
            nw = int'($urandom_range(4, 1));
            q.push_back(8'hA5);
            q.push_back(8'(nw));
            q.push_back(8'h00);
            for (int j = 0; j < 4 * nw; j++) begin
                q.push_back(8'($urandom_range(255, 0)));
                s = s + q[q.size() - 1];
            end
`ifdef UPG_CHKSUM_EN
            q.push_back(($urandom_range(3, 0) == 0) ? s + 8'h01 : s);
`endif
            if ($urandom_range(6, 0) == 0) void'(q.pop_back());
            model_frame(q);
            got_q.delete();
            pulse_start();
            foreach (q[k]) begin
                send_byte(q[k]);
                idle(int'($urandom_range(3, 0)));
            end
            idle(TMO + 5);
            check($sformatf("rnd%0d done", f), 64'(upg_done_o), 64'(exp_done));
            check($sformatf("rnd%0d err", f), 64'(err_o), 64'(exp_err));
            check($sformatf("rnd%0d nwrites", f), 64'(got_q.size()), 64'(exp_q.size()));
            nd = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
            for (int k = 0; k < nd; k++)
                check($sformatf("rnd%0d write%0d", f, k), 64'(got_q[k]), 64'(exp_q[k]));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
